// File: rtl/uartrx_fifo.sv
// Receive-side byte FIFO between uartrx and the CPU's UART-in register.
// Acknowledges every received byte and flags overrun when a byte is dropped at full.
module uartrx_fifo #(
  parameter int DepthBitWidth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   rx_go,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  input  logic                   pop,
  output logic [7:0]             rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [DepthBitWidth:0] count,
  output logic                   overrun,
  input  logic                   clr_overrun
);

  localparam int Depth = 1 << DepthBitWidth;
  localparam logic [DepthBitWidth:0]   FullCount = (DepthBitWidth + 1)'(Depth);
  localparam logic [DepthBitWidth:0]   CntOne    = (DepthBitWidth + 1)'(1);
  localparam logic [DepthBitWidth-1:0] PtrOne    = DepthBitWidth'(1);

  typedef enum logic {
    RECV = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [7:0]               mem [Depth];
  logic [DepthBitWidth-1:0] wptr, rptr;
  logic [DepthBitWidth:0]   cnt;
  logic                     capture, do_pop, do_write, drop;

  // Handshake FSM: a byte is captured in RECV, then acknowledged for one cycle in ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RECV;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    rx_go      = 1'b1;
    case (state)
      RECV: begin
        if (rx_ready) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        rx_go      = 1'b0;
        state_next = RECV;
      end
      default: state_next = RECV;
    endcase
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == FullCount);
  assign count = cnt;

  // At full a same-cycle pop frees the slot being written, so the byte is kept.
  assign do_pop   = pop && !empty;
  assign do_write = capture && (!full || do_pop);
  assign drop     = capture && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_write) wptr <= wptr + PtrOne;
      if (do_pop)   rptr <= rptr + PtrOne;
      case ({do_write, do_pop})
        2'b10:   cnt <= cnt + CntOne;
        2'b01:   cnt <= cnt - CntOne;
        default: cnt <= cnt;
      endcase
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // Storage needs no reset: stale contents are hidden while empty.
  always_ff @(posedge clk) begin
    if (do_write) mem[wptr] <= rx_data;
  end

  assign rd_data = empty ? 8'h00 : mem[rptr];

endmodule

// File: tb/tb_uartrx_fifo.sv
// Self-checking bench for uartrx_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_uartrx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_go;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       pop;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       clr_overrun;

  int total = 0;
  int bad   = 0;

  // Reference model: byte queue, sticky overrun, and whether the next cycle is an acknowledge cycle.
  logic [7:0] q[$];
  bit         m_ovr;
  bit         m_ack;
  bit         pop_done;
  logic [7:0] pop_obs;
  logic [7:0] pop_exp;

  uartrx_fifo #(.DepthBitWidth(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_go      (rx_go),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .pop        (pop),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Drive one clock cycle of inputs and advance the model by the same cycle.
  task automatic cycle(input bit rdy, input logic [7:0] d, input bit p, input bit c);
    bit drop;
    @(negedge clk);
    rx_ready = rdy; rx_data = d; pop = p; clr_overrun = c;
    #1;
    pop_obs  = rd_data;
    pop_done = p && (q.size() > 0);
    pop_exp  = pop_done ? q[0] : 8'h00;
    if (pop_done) void'(q.pop_front());
    drop = 1'b0;
    if (rdy && !m_ack) begin
      if (q.size() < 16) q.push_back(d);
      else drop = 1'b1;
      m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
    if (drop)   m_ovr = 1'b1;
    else if (c) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    rx_ready = 1'b0; pop = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_ready = 1'b0; pop = 1'b0; clr_overrun = 1'b0; rx_data = 8'h00;
    q.delete(); m_ovr = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    total++;
    if (count !== 5'd3) begin bad++; $display("[TB] FAIL reset_prefill count got=%0d want=3", count); end
    // Assert reset while a new byte is arriving
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'hEE;
    #1 rst_n = 1'b0;
    #2;
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00 || rx_go !== 1'b1 ||
        overrun !== 1'b0 || full !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state got count=%0d empty=%b rd=%h go=%b ovr=%b full=%b want 0 1 00 1 0 0",
               count, empty, rd_data, rx_go, overrun, full);
    end
    rx_ready = 1'b0;
    q.delete(); m_ovr = 1'b0; m_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if (count !== 5'd0 || rx_go !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_release got count=%0d go=%b want 0 1", count, rx_go);
    end
  endtask

  task automatic test_single();
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    total++;
    if (rx_go !== 1'b0 || count !== 5'd1 || rd_data !== 8'h41) begin
      bad++; $display("[TB] FAIL single_push got go=%b count=%0d rd=%h want 0 1 41", rx_go, count, rd_data);
    end
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    total++;
    if (rx_go !== 1'b1 || count !== 5'd1) begin
      bad++; $display("[TB] FAIL single_ack got go=%b count=%0d want 1 1", rx_go, count);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (pop_obs !== 8'h41 || empty !== 1'b1 || rd_data !== 8'h00) begin
      bad++; $display("[TB] FAIL single_pop got head=%h empty=%b rd=%h want 41 1 00", pop_obs, empty, rd_data);
    end
  endtask

  task automatic test_order_wrap();
    int expect_next = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, (i % 4) == 3, 1'b0);
      if (pop_done) begin
        total++;
        if (pop_obs !== 8'(expect_next)) begin
          bad++; $display("[TB] FAIL order_mid got=%h want=%h", pop_obs, 8'(expect_next));
        end
        expect_next++;
      end
    end
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (pop_obs !== 8'(expect_next) || pop_obs !== pop_exp) begin
        bad++; $display("[TB] FAIL order_drain got=%h want=%h", pop_obs, 8'(expect_next));
      end
      expect_next++;
    end
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || expect_next != 20) begin
      bad++; $display("[TB] FAIL order_end got count=%0d empty=%b out=%0d want 0 1 20", count, empty, expect_next);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    total++;
    if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1) begin
      bad++; $display("[TB] FAIL overrun_full got full=%b count=%0d ovr=%b want 1 16 1", full, count, overrun);
    end
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (pop_obs !== 8'h10 + 8'(k)) begin
        bad++; $display("[TB] FAIL overrun_drain got=%h want=%h", pop_obs, 8'h10 + 8'(k));
      end
    end
    total++;
    if (empty !== 1'b1 || overrun !== 1'b1) begin
      bad++; $display("[TB] FAIL overrun_sticky got empty=%b ovr=%b want 1 1", empty, overrun);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("[TB] FAIL overrun_clear got=%b want=0", overrun);
    end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0);
    end
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    total++;
    if (count !== 5'd16 || overrun !== 1'b0 || pop_obs !== 8'hC0) begin
      bad++; $display("[TB] FAIL simul_full got count=%0d ovr=%b head=%h want 16 0 c0", count, overrun, pop_obs);
    end
    for (int k = 0; k < 16; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (pop_obs !== ((k == 15) ? 8'h55 : 8'hC1 + 8'(k))) begin
        bad++; $display("[TB] FAIL simul_drain got=%h want=%h", pop_obs, (k == 15) ? 8'h55 : 8'hC1 + 8'(k));
      end
    end
  endtask

  task automatic test_pop_empty();
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (count !== 5'd0 || rd_data !== 8'h00 || empty !== 1'b1) begin
      bad++; $display("[TB] FAIL pop_empty got count=%0d rd=%h want 0 00", count, rd_data);
    end
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    total++;
    if (count !== 5'd1 || rd_data !== 8'h77) begin
      bad++; $display("[TB] FAIL push_pop_empty got count=%0d rd=%h want 1 77", count, rd_data);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      total++;
      if (count !== 5'(q.size()) || rd_data !== ((q.size() > 0) ? q[0] : 8'h00) ||
          overrun !== m_ovr || rx_go !== !m_ack || full !== (q.size() == 16)) begin
        bad++;
        $display("[TB] FAIL random_state cyc=%0d got count=%0d rd=%h ovr=%b go=%b want %0d %h %b %b",
                 n, count, rd_data, overrun, rx_go, q.size(), (q.size() > 0) ? q[0] : 8'h00, m_ovr, !m_ack);
      end
      if (pop_done) begin
        total++;
        if (pop_obs !== pop_exp) begin
          bad++; $display("[TB] FAIL random_pop cyc=%0d got=%h want=%h", n, pop_obs, pop_exp);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    do_reset();
    $display("[TB] reset"); test_reset();
    $display("[TB] single"); test_single();
    $display("[TB] order/wrap"); test_order_wrap();
    do_reset();
    $display("[TB] overrun"); test_overrun();
    do_reset();
    $display("[TB] simultaneous at full"); test_simul_full();
    $display("[TB] pop when empty"); test_pop_empty();
    do_reset();
    $display("[TB] random"); test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
